// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: frame byte constants and scheduler state encoding shared with host-side decoders
package spi_frame_pkg;
  localparam logic [7:0] SOF = 8'hA5;
  localparam logic [7:0] IDLE_CH = 8'hFF;
  localparam logic [7:0] PAD = 8'hFF;
  typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_CHAN, ST_LEN, ST_PAY, ST_CSUM, ST_PAD} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick (lowest requester at or above i_ptr, wrapping); in: i_req, i_ptr; out: o_grant_valid, o_grant_id
module rr_arbiter #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [CH_W-1:0] i_ptr,
  output logic            o_grant_valid,
  output logic [CH_W-1:0] o_grant_id
);
  always_comb begin
    o_grant_id = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (i_req[(int'(i_ptr) + i) % N_CH]) o_grant_id = CH_W'((int'(i_ptr) + i) % N_CH);
  end
  assign o_grant_valid = |i_req;
endmodule

// File: rtl/spi_tx_scheduler.sv
// spi_tx_scheduler: one SPI frame per chip-select window (SOF, channel, length, payload, XOR checksum, pad); in: clk, rst_n, ssel_*, byte_sent, req/req_len/rd_data/rd_empty; out: tx_data, tx_enable, pop, grant_*, frame_done/abort, underrun
module spi_tx_scheduler
  import spi_frame_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ssel_active,
  input  logic              ssel_start,
  input  logic              byte_sent,
  output logic [7:0]        tx_data,
  output logic              tx_enable,
  input  logic [N_CH-1:0]   req,
  input  logic [8*N_CH-1:0] req_len,
  input  logic [8*N_CH-1:0] rd_data,
  input  logic [N_CH-1:0]   rd_empty,
  output logic [N_CH-1:0]   pop,
  output logic              grant_valid,
  output logic [CH_W-1:0]   grant_id,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              underrun
);
  state_t r_state, w_next;
  logic [CH_W-1:0] r_ptr, r_gid, w_arb_gid;
  logic r_gv, r_en, r_done, r_abort, r_under, w_arb_gv;
  logic [7:0] r_cnt, r_csum, r_tx;
  logic w_adv, w_drop, w_pop_en;
  logic [7:0] w_len, w_pay, w_chan;
  rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
    .i_req(req), .i_ptr(r_ptr), .o_grant_valid(w_arb_gv), .o_grant_id(w_arb_gid)
  );
  assign w_adv = byte_sent && ssel_active;
  assign w_drop = !ssel_active && r_state != ST_IDLE;
  assign w_pop_en = w_adv && (r_state == ST_LEN || r_state == ST_PAY) && r_cnt != 8'd0;
  assign w_len = req_len[w_arb_gid*8 +: 8];
  assign w_pay = rd_empty[r_gid] ? 8'h00 : rd_data[r_gid*8 +: 8];
  assign w_chan = r_gv ? 8'(r_gid) : IDLE_CH;
  always_comb begin
    w_next = r_state;
    if (r_state == ST_IDLE) w_next = ssel_start ? ST_HDR : ST_IDLE;
    else if (!ssel_active) w_next = ST_IDLE;
    else if (byte_sent)
      case (r_state)
        ST_HDR:          w_next = ST_CHAN;
        ST_CHAN:         w_next = ST_LEN;
        ST_LEN, ST_PAY:  w_next = r_cnt != 8'd0 ? ST_PAY : ST_CSUM;
        ST_CSUM:         w_next = ST_PAD;
        default:         w_next = r_state;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr <= '0;
      r_gid <= '0;
      r_gv <= 1'b0;
      r_en <= 1'b0;
      r_done <= 1'b0;
      r_abort <= 1'b0;
      r_under <= 1'b0;
      r_cnt <= 8'd0;
      r_csum <= 8'd0;
      r_tx <= SOF;
    end else begin
      r_state <= w_next;
      r_en <= 1'b1;
      r_done <= r_state == ST_CSUM && w_adv;
      r_abort <= w_drop && r_gv && r_state != ST_PAD;
      if (w_pop_en && rd_empty[r_gid]) r_under <= 1'b1;
      if (w_drop) begin
        r_tx <= SOF;
        r_gv <= 1'b0;
      end else if (r_state == ST_IDLE && ssel_start) begin
        r_gv <= w_arb_gv;
        r_gid <= w_arb_gid;
        r_cnt <= w_arb_gv ? w_len : 8'd0;
        r_csum <= 8'd0;
        r_tx <= SOF;
      end else if (w_adv)
        case (r_state)
          ST_HDR: begin
            r_tx <= w_chan;
            r_csum <= w_chan;
          end
          ST_CHAN: begin
            r_tx <= r_cnt;
            r_csum <= r_csum ^ r_cnt;
          end
          ST_LEN, ST_PAY:
            if (r_cnt != 8'd0) begin
              r_tx <= w_pay;
              r_csum <= r_csum ^ w_pay;
              r_cnt <= r_cnt - 8'd1;
            end else r_tx <= r_csum;
          ST_CSUM: begin
            r_tx <= PAD;
            if (r_gv) r_ptr <= int'(r_gid) == N_CH - 1 ? '0 : r_gid + CH_W'(1);
          end
          default: r_tx <= r_tx;
        endcase
    end
  assign pop = w_pop_en ? N_CH'(1) << r_gid : '0;
  assign tx_data = r_tx;
  assign tx_enable = r_en;
  assign grant_valid = r_gv;
  assign grant_id = r_gid;
  assign frame_done = r_done;
  assign frame_abort = r_abort;
  assign underrun = r_under;
endmodule

// File: tb/tb_spi_tx_scheduler.sv
// tb_spi_tx_scheduler: directed self-checking bench for spi_tx_scheduler
module tb_spi_tx_scheduler;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ssel_active = 1'b0, ssel_start = 1'b0, byte_sent = 1'b0;
  logic [7:0] tx_data;
  logic tx_enable, grant_valid, frame_done, frame_abort, underrun;
  logic [3:0] req = '0, rd_empty = '0, pop;
  logic [31:0] req_len = '0, rd_data = '0;
  logic [1:0] grant_id;
  int total = 0, bad = 0;
  spi_tx_scheduler #(.N_CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .ssel_active(ssel_active), .ssel_start(ssel_start),
    .byte_sent(byte_sent), .tx_data(tx_data), .tx_enable(tx_enable), .req(req),
    .req_len(req_len), .rd_data(rd_data), .rd_empty(rd_empty), .pop(pop),
    .grant_valid(grant_valid), .grant_id(grant_id), .frame_done(frame_done),
    .frame_abort(frame_abort), .underrun(underrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic sb(input string tag, input logic [7:0] e_tx, input logic [3:0] e_pop);
    byte_sent = 1'b1;
    #1 chk({tag, "_pop"}, 32'(pop), 32'(e_pop));
    @(negedge clk) byte_sent = 1'b0;
    chk(tag, 32'(tx_data), 32'(e_tx));
  endtask
  task automatic start(input string tag, input logic e_gv, input logic [1:0] e_gid);
    ssel_active = 1'b1;
    ssel_start = 1'b1;
    @(negedge clk) ssel_start = 1'b0;
    chk({tag, "_gv"}, 32'(grant_valid), 32'(e_gv));
    chk({tag, "_gid"}, 32'(grant_id), 32'(e_gid));
    chk({tag, "_sof"}, 32'(tx_data), 32'hA5);
  endtask
  task automatic end_cs(input string tag);
    ssel_active = 1'b0;
    @(negedge clk);
    chk({tag, "_noabort"}, 32'(frame_abort), 32'd0);
    chk({tag, "_idle_tx"}, 32'(tx_data), 32'hA5);
  endtask
  task automatic frame0(input string tag, input logic [1:0] g);
    start(tag, 1'b1, g);
    sb({tag, "_ch"}, 8'(g), 4'h0);
    sb({tag, "_len"}, 8'h00, 4'h0);
    sb({tag, "_cs"}, 8'(g), 4'h0);
    sb({tag, "_pad"}, 8'hFF, 4'h0);
    chk({tag, "_done"}, 32'(frame_done), 32'd1);
    end_cs(tag);
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(tx_data), 32'hA5);
    chk("rst_en", 32'(tx_enable), 32'd0);
    chk("rst_outs", {24'(pop), 4'(grant_id), grant_valid, frame_done, frame_abort, underrun}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("en_after_rst", 32'(tx_enable), 32'd1);
    rd_empty = 4'hF;
    start("idle", 1'b0, 2'd0);
    sb("idle_ch", 8'hFF, 4'h0);
    sb("idle_len", 8'h00, 4'h0);
    sb("idle_cs", 8'hFF, 4'h0);
    sb("idle_pad", 8'hFF, 4'h0);
    chk("idle_done", 32'(frame_done), 32'd1);
    chk("idle_gv", 32'(grant_valid), 32'd0);
    @(negedge clk);
    chk("idle_done_pulse", 32'(frame_done), 32'd0);
    sb("idle_pad2", 8'hFF, 4'h0);
    end_cs("idle");
    sb("bs_in_idle", 8'hA5, 4'h0);
    rd_empty = 4'h0;
    req = 4'b1011;
    frame0("rr0", 2'd0);
    frame0("rr1", 2'd1);
    frame0("rr3", 2'd3);
    req = 4'b0100;
    req_len[23:16] = 8'd3;
    start("single", 1'b1, 2'd2);
    sb("single_ch", 8'h02, 4'h0);
    sb("single_len", 8'h03, 4'h0);
    rd_data[23:16] = 8'h11;
    sb("single_p1", 8'h11, 4'b0100);
    rd_data[23:16] = 8'h22;
    sb("single_p2", 8'h22, 4'b0100);
    rd_data[23:16] = 8'h33;
    sb("single_p3", 8'h33, 4'b0100);
    sb("single_cs", 8'h01, 4'h0);
    sb("single_pad", 8'hFF, 4'h0);
    chk("single_done", 32'(frame_done), 32'd1);
    req = 4'b0110;
    end_cs("single");
    req_len[15:8] = 8'd4;
    start("abort", 1'b1, 2'd1);
    sb("abort_ch", 8'h01, 4'h0);
    sb("abort_len", 8'h04, 4'h0);
    rd_data[15:8] = 8'hA1;
    sb("abort_p1", 8'hA1, 4'b0010);
    rd_data[15:8] = 8'hA2;
    sb("abort_p2", 8'hA2, 4'b0010);
    ssel_active = 1'b0;
    byte_sent = 1'b1;
    #1 chk("drop_nopop", 32'(pop), 32'd0);
    @(negedge clk) byte_sent = 1'b0;
    chk("abort_pulse", 32'(frame_abort), 32'd1);
    chk("abort_tx", 32'(tx_data), 32'hA5);
    chk("abort_gv", 32'(grant_valid), 32'd0);
    @(negedge clk);
    chk("abort_one_clk", 32'(frame_abort), 32'd0);
    start("retry", 1'b1, 2'd1);
    sb("retry_ch", 8'h01, 4'h0);
    sb("retry_len", 8'h04, 4'h0);
    rd_data[15:8] = 8'hB1;
    sb("retry_p1", 8'hB1, 4'b0010);
    rd_data[15:8] = 8'hB2;
    sb("retry_p2", 8'hB2, 4'b0010);
    rd_data[15:8] = 8'hB3;
    sb("retry_p3", 8'hB3, 4'b0010);
    rd_data[15:8] = 8'hB4;
    sb("retry_p4", 8'hB4, 4'b0010);
    sb("retry_cs", 8'h01, 4'h0);
    sb("retry_pad", 8'hFF, 4'h0);
    req = 4'b0001;
    end_cs("retry");
    req_len[7:0] = 8'd2;
    start("under", 1'b1, 2'd0);
    sb("under_ch", 8'h00, 4'h0);
    sb("under_len", 8'h02, 4'h0);
    rd_data[7:0] = 8'hC1;
    sb("under_p1", 8'hC1, 4'b0001);
    chk("under_clear", 32'(underrun), 32'd0);
    rd_empty[0] = 1'b1;
    sb("under_p2", 8'h00, 4'b0001);
    chk("under_set", 32'(underrun), 32'd1);
    rd_empty[0] = 1'b0;
    sb("under_cs", 8'hC3, 4'h0);
    sb("under_pad", 8'hFF, 4'h0);
    req = 4'b0010;
    end_cs("under");
    chk("under_sticky", 32'(underrun), 32'd1);
    req_len[15:8] = 8'd2;
    start("rst", 1'b1, 2'd1);
    sb("rst_ch", 8'h01, 4'h0);
    sb("rst_len", 8'h02, 4'h0);
    rd_data[15:8] = 8'hD1;
    sb("rst_p1", 8'hD1, 4'b0010);
    rst_n = 1'b0;
    #1 chk("midrst_tx", 32'(tx_data), 32'hA5);
    chk("midrst_en", 32'(tx_enable), 32'd0);
    chk("midrst_outs", {24'(pop), 4'(grant_id), grant_valid, frame_done, frame_abort, underrun}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    ssel_active = 1'b0;
    @(negedge clk);
    req = 4'b0011;
    req_len = '0;
    start("post_rst", 1'b1, 2'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
